// File: rtl/mshr_replay_queue_p.sv
// rtl/mshr_replay_queue_p.sv - parametrised MSHR replay queue with flow/pipe modes, flush, almost-full and high-water mark
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   enq_valid/ready   producer handshake, enq_bits is the packed request
//   deq_valid/ready   consumer handshake, deq_bits is the head request
//   flush             discard all entries (next cycle the queue is empty)
//   count             current occupancy 0..DEPTH
//   almost_full       count >= AF_THRESH
//   hwm               maximum occupancy since reset or last hwm_clear
//   hwm_clear         reload hwm with the post-update occupancy
module mshr_replay_queue_p #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int FLOW      = 0,
    parameter int PIPE      = 0,
    parameter int AF_THRESH = 12,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_bits,
    input  logic              flush,
    output logic [CW-1:0]     count,
    output logic              almost_full,
    output logic [CW-1:0]     hwm,
    input  logic              hwm_clear
);

    localparam bit             FLOW_EN = (FLOW != 0);
    localparam bit             PIPE_EN = (PIPE != 0);
    localparam logic [AW-1:0]  PTR_ONE = AW'(1);
    localparam logic [CW-1:0]  AF_LVL  = CW'(AF_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mshr_replay_queue_p: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("mshr_replay_queue_p: AF_THRESH must lie in 1..DEPTH");
    end

    // Payload storage is deliberately left unreset; only pointers define validity.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic          mf_q, mf_d;
    logic [CW-1:0] hwm_q, hwm_d;

    logic          ptr_match, empty, full;
    logic          do_enq, do_deq, flow_thru, wr_en, rd_adv;
    logic [AW-1:0] diff, diff_d;
    logic          full_d;
    logic [CW-1:0] count_next;

    assign ptr_match = (wp_q == rp_q);
    assign empty     = ptr_match & ~mf_q;
    assign full      = ptr_match &  mf_q;
    assign diff      = wp_q - rp_q;

    always_comb begin
        enq_ready   = 1'b0;
        deq_valid   = 1'b0;
        deq_bits    = mem_q[rp_q];
        count       = {full, diff};
        almost_full = (count >= AF_LVL);
        hwm         = hwm_q;

        if (!reset && !flush) begin
            // deq_ready only reaches enq_ready in PIPE mode, and only when full.
            enq_ready = ~full | (PIPE_EN & full & deq_ready);
            deq_valid = ~empty | (FLOW_EN & empty & enq_valid);
        end
        if (FLOW_EN && empty) begin
            deq_bits = enq_bits;
        end
    end

    assign do_enq    = enq_valid & enq_ready;
    assign do_deq    = deq_valid & deq_ready;
    // In flow mode an element entering and leaving an empty queue never touches storage.
    assign flow_thru = FLOW_EN & empty & do_enq & do_deq;
    assign wr_en     = do_enq & ~flow_thru;
    assign rd_adv    = do_deq & ~flow_thru;

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        mf_d = mf_q;
        if (reset || flush) begin
            wp_d = '0;
            rp_d = '0;
            mf_d = 1'b0;
        end else begin
            if (wr_en) begin
                wp_d = wp_q + PTR_ONE;
            end
            if (rd_adv) begin
                rp_d = rp_q + PTR_ONE;
            end
            // Equal-pointer ambiguity is resolved by remembering which side moved last.
            if (wr_en != rd_adv) begin
                mf_d = wr_en;
            end
        end
    end

    assign diff_d     = wp_d - rp_d;
    assign full_d     = (wp_d == rp_d) & mf_d;
    assign count_next = {full_d, diff_d};

    always_comb begin
        hwm_d = hwm_q;
        if (reset) begin
            hwm_d = '0;
        end else if (hwm_clear) begin
            hwm_d = count_next;
        end else if (count_next > hwm_q) begin
            hwm_d = count_next;
        end
    end

    always_ff @(posedge clk) begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        mf_q  <= mf_d;
        hwm_q <= hwm_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset && !flush) begin
            mem_q[wp_q] <= enq_bits;
        end
    end

endmodule

// File: tb/tb_mshr_replay_queue_p.sv
// tb/tb_mshr_replay_queue_p.sv - directed self-checking bench for mshr_replay_queue_p
module tb_mshr_replay_queue_p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enq_valid = 1'b0;
    logic [7:0] enq_bits = 8'h00;
    logic       deq_ready = 1'b0;
    logic       flush = 1'b0;
    logic       hwm_clear = 1'b0;

    logic       b_enq_ready, b_deq_valid, b_af;
    logic [7:0] b_deq_bits;
    logic [2:0] b_count, b_hwm;
    logic       f_enq_ready, f_deq_valid, f_af;
    logic [7:0] f_deq_bits;
    logic [2:0] f_count, f_hwm;
    logic       p_enq_ready, p_deq_valid, p_af;
    logic [7:0] p_deq_bits;
    logic [2:0] p_count, p_hwm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mshr_replay_queue_p #(.DATA_W(8), .DEPTH(4), .FLOW(0), .PIPE(0), .AF_THRESH(3)) u_base (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(b_enq_ready), .enq_bits(enq_bits),
        .deq_valid(b_deq_valid), .deq_ready(deq_ready), .deq_bits(b_deq_bits),
        .flush(flush), .count(b_count), .almost_full(b_af), .hwm(b_hwm), .hwm_clear(hwm_clear)
    );

    mshr_replay_queue_p #(.DATA_W(8), .DEPTH(4), .FLOW(1), .PIPE(0), .AF_THRESH(3)) u_flow (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(f_enq_ready), .enq_bits(enq_bits),
        .deq_valid(f_deq_valid), .deq_ready(deq_ready), .deq_bits(f_deq_bits),
        .flush(flush), .count(f_count), .almost_full(f_af), .hwm(f_hwm), .hwm_clear(hwm_clear)
    );

    mshr_replay_queue_p #(.DATA_W(8), .DEPTH(4), .FLOW(0), .PIPE(1), .AF_THRESH(3)) u_pipe (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(p_enq_ready), .enq_bits(enq_bits),
        .deq_valid(p_deq_valid), .deq_ready(deq_ready), .deq_bits(p_deq_bits),
        .flush(flush), .count(p_count), .almost_full(p_af), .hwm(p_hwm), .hwm_clear(hwm_clear)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic ev, input logic [7:0] bits, input logic dr,
                        input logic fl, input logic hc);
        @(negedge clk);
        enq_valid = ev;
        enq_bits  = bits;
        deq_ready = dr;
        flush     = fl;
        hwm_clear = hc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0; hwm_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin : stim
        logic [7:0] mq[$];
        int         ev_v[9];
        int         dr_v[9];
        int         k;
        int         sz;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_enq_ready", 16'(b_enq_ready), 16'h0);
        chk("rst_deq_valid", 16'(b_deq_valid), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_enq_ready", 16'(b_enq_ready), 16'h1);
        chk("post_rst_deq_valid", 16'(b_deq_valid), 16'h0);
        chk("post_rst_count", 16'(b_count), 16'h0);
        chk("post_rst_af", 16'(b_af), 16'h0);
        chk("post_rst_hwm", 16'(b_hwm), 16'h0);

        // 1: fill to full then drain in order
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
            chk("t1_enq_ready", 16'(b_enq_ready), 16'h1);
            chk("t1_count", 16'(b_count), 16'(i));
            chk("t1_af", 16'(b_af), (i >= 3) ? 16'h1 : 16'h0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t1_full_count", 16'(b_count), 16'h4);
        chk("t1_full_enq_ready", 16'(b_enq_ready), 16'h0);
        chk("t1_full_af", 16'(b_af), 16'h1);
        chk("t1_full_hwm", 16'(b_hwm), 16'h4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("t1_drain_valid", 16'(b_deq_valid), 16'h1);
            chk("t1_drain_bits", 16'(b_deq_bits), 16'(8'hA0 + 8'(i)));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t1_empty_valid", 16'(b_deq_valid), 16'h0);
        chk("t1_empty_count", 16'(b_count), 16'h0);
        chk("t1_empty_hwm", 16'(b_hwm), 16'h4);

        // 2: interleaved enq/deq so both pointers wrap
        ev_v = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
        dr_v = '{0, 0, 1, 1, 1, 0, 1, 1, 1};
        k = 0;
        for (int s = 0; s < 9; s++) begin
            step(ev_v[s] != 0, 8'h10 + 8'(k), dr_v[s] != 0, 1'b0, 1'b0);
            sz = mq.size();
            chk("t2_count", 16'(b_count), 16'(sz));
            if (dr_v[s] != 0 && sz > 0) begin
                chk("t2_deq_valid", 16'(b_deq_valid), 16'h1);
                chk("t2_deq_bits", 16'(b_deq_bits), 16'(mq[0]));
                void'(mq.pop_front());
            end
            if (ev_v[s] != 0 && sz < 4) begin
                mq.push_back(8'h10 + 8'(k));
                k++;
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2_end_count", 16'(b_count), 16'h0);
        chk("t2_end_valid", 16'(b_deq_valid), 16'h0);

        // 3: flow-through on empty queue
        do_reset();
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("t3_flow_valid", 16'(f_deq_valid), 16'h1);
        chk("t3_flow_bits", 16'(f_deq_bits), 16'h55);
        chk("t3_flow_enq_ready", 16'(f_enq_ready), 16'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t3_after_count", 16'(f_count), 16'h0);
        chk("t3_after_valid", 16'(f_deq_valid), 16'h0);
        chk("t3_after_hwm", 16'(f_hwm), 16'h0);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        chk("t3_stall_valid", 16'(f_deq_valid), 16'h1);
        chk("t3_stall_bits", 16'(f_deq_bits), 16'h66);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t3_stored_count", 16'(f_count), 16'h1);
        chk("t3_stored_bits", 16'(f_deq_bits), 16'h66);

        // 4: pipe mode enq into a full queue
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0);
        chk("t4_full_count", 16'(p_count), 16'h4);
        chk("t4_full_enq_ready", 16'(p_enq_ready), 16'h0);
        step(1'b1, 8'hB4, 1'b1, 1'b0, 1'b0);
        chk("t4_pipe_enq_ready", 16'(p_enq_ready), 16'h1);
        chk("t4_pipe_deq_bits", 16'(p_deq_bits), 16'hB0);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (i == 1) chk("t4_still_full", 16'(p_count), 16'h4);
            chk("t4_drain_bits", 16'(p_deq_bits), 16'(8'hB0 + 8'(i)));
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t4_end_count", 16'(p_count), 16'h0);

        // 5: flush with a pending enq and deq
        do_reset();
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 8'hC0, 1'b1, 1'b1, 1'b0);
        chk("t5_flush_enq_ready", 16'(b_enq_ready), 16'h0);
        chk("t5_flush_deq_valid", 16'(b_deq_valid), 16'h0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_post_count", 16'(b_count), 16'h0);
        chk("t5_post_valid", 16'(b_deq_valid), 16'h0);
        chk("t5_post_hwm", 16'(b_hwm), 16'h3);
        step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_d0_valid", 16'(b_deq_valid), 16'h1);
        chk("t5_d0_bits", 16'(b_deq_bits), 16'hD0);

        // 6: reset mid-operation, then hwm_clear with a simultaneous enq
        do_reset();
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; enq_valid = 1'b1; enq_bits = 8'h43; deq_ready = 1'b1;
        #1;
        chk("t6_rst_enq_ready", 16'(b_enq_ready), 16'h0);
        chk("t6_rst_deq_valid", 16'(b_deq_valid), 16'h0);
        @(negedge clk);
        reset = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        #1;
        chk("t6_post_count", 16'(b_count), 16'h0);
        chk("t6_post_hwm", 16'(b_hwm), 16'h0);
        chk("t6_post_af", 16'(b_af), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_clr_count", 16'(b_count), 16'h1);
        chk("t6_pre_clr_hwm", 16'(b_hwm), 16'h3);
        step(1'b1, 8'h54, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6_clr_hwm", 16'(b_hwm), 16'h2);
        chk("t6_clr_count", 16'(b_count), 16'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
